// File: rtl/prng_pkg.sv
// Shared types, constants and the single-step Galois LFSR helper for the
// lfsr_prng_gen pseudo-random word generator.
package prng_pkg;

    // Generator sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } prng_state_e;

    // x^32 + x^7 + x^5 + x^3 + x^2 + x + 1, bit k = coefficient of x^k.
    localparam logic [31:0] POLY32_DEFAULT = 32'h0000_00AF;

    // Widest LFSR the helper supports.
    localparam int MAX_WIDTH = 64;

    // One Galois shift of a width-bit register held in the low bits of s:
    // shift left, and if the bit leaving the top was set, fold in the taps.
    function automatic logic [MAX_WIDTH-1:0] lfsr_step(
        input logic [MAX_WIDTH-1:0] s,
        input logic [MAX_WIDTH-1:0] taps,
        input int                   width
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] nxt;
        mask = (width >= MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        nxt  = {s[MAX_WIDTH-2:0], 1'b0} ^ (s[6'(width - 1)] ? taps : '0);
        return nxt & mask;
    endfunction

endpackage : prng_pkg

// File: rtl/lfsr_advance.sv
// Combinational LFSR advance: applies STEPS Galois shifts to the incoming
// state in a single cycle. Shared by the warm-up and run paths of the top.
module lfsr_advance
    import prng_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(POLY32_DEFAULT),
    parameter int               STEPS = 1
) (
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out
);

    logic [MAX_WIDTH-1:0] acc;

    // Unrolled chain of STEPS single shifts.
    always_comb begin
        // NOTE: acc is a combinational scratch variable chained through the
        // loop, so it is written with blocking assignments; each iteration
        // must see the previous iteration's result immediately.
        acc = MAX_WIDTH'(state_in);
        for (int i = 0; i < STEPS; i++) begin
            acc = lfsr_step(acc, MAX_WIDTH'(TAPS), WIDTH);
        end
        state_out = acc[WIDTH-1:0];
    end

endmodule : lfsr_advance

// File: rtl/lfsr_prng_gen.sv
// Parametrised Galois-LFSR pseudo-random word generator with a valid/ready
// output handshake, seed-load handshake, zero-seed guard and an
// IDLE/WARMUP/RUN sequencer.
// Optional build macro PRNG_LOCKUP_RECOVER_EN: adds the sticky lockup_err
// output and recovery from an all-zero state while warming up or running.
module lfsr_prng_gen
    import prng_pkg::prng_state_e, prng_pkg::POLY32_DEFAULT;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(POLY32_DEFAULT),
    parameter int               OUT_W        = 32,
    parameter int               STEPS        = 1,
    parameter int               WARMUP       = 0,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic [WIDTH-1:0] seed,
    output logic             o_valid,
    input  logic             o_ready,
`ifdef PRNG_LOCKUP_RECOVER_EN
    output logic             lockup_err,
`endif
    output logic [OUT_W-1:0] o_data
);

    // Parameter legality, rejected at elaboration.
    if (WIDTH < 3 || WIDTH > 64) begin : g_bad_width
        $fatal(1, "lfsr_prng_gen: WIDTH must be 3..64");
    end
    if (TAPS[0] == 1'b0) begin : g_bad_taps
        $fatal(1, "lfsr_prng_gen: TAPS[0] must be 1");
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
        $fatal(1, "lfsr_prng_gen: OUT_W must be 1..WIDTH");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $fatal(1, "lfsr_prng_gen: STEPS must be 1..WIDTH");
    end
    if (WARMUP < 0 || WARMUP > 255) begin : g_bad_warmup
        $fatal(1, "lfsr_prng_gen: WARMUP must be 0..255");
    end
    if (SEED_DEFAULT == '0) begin : g_bad_seed_default
        $fatal(1, "lfsr_prng_gen: SEED_DEFAULT must be non-zero");
    end

    localparam logic [7:0] WARM_INIT = 8'(WARMUP);

    logic [WIDTH-1:0] state_q, state_d, state_adv;
    prng_state_e      fsm_q, fsm_d;
    logic [7:0]       warm_cnt_q, warm_cnt_d;
    logic             lockup_det;

    lfsr_advance #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .STEPS (STEPS)
    ) u_adv (
        .state_in  (state_q),
        .state_out (state_adv)
    );

`ifdef PRNG_LOCKUP_RECOVER_EN
    logic lockup_err_q, lockup_err_d;

    // An all-zero state is a fixed point of the LFSR; flag it while active.
    assign lockup_det = (fsm_q != prng_pkg::IDLE) && (state_q == '0);
    assign lockup_err = lockup_err_q;
`else
    assign lockup_det = 1'b0;
`endif

    // Seed is always accepted once out of reset.
    assign seed_ready = rst_n;
    assign o_valid    = (fsm_q == prng_pkg::RUN) && !lockup_det;
    assign o_data     = state_q[OUT_W-1:0];

    // Next-state selection: seed load wins, then lockup recovery, then the
    // per-state advance.
    always_comb begin
        // NOTE: each next-value is given its hold value first, so every path
        // through the branches assigns it and no latch is inferred.
        state_d    = state_q;
        fsm_d      = fsm_q;
        warm_cnt_d = warm_cnt_q;
`ifdef PRNG_LOCKUP_RECOVER_EN
        lockup_err_d = lockup_err_q;
`endif
        if (seed_valid) begin
            state_d = (seed == '0) ? SEED_DEFAULT : seed;
`ifdef PRNG_LOCKUP_RECOVER_EN
            lockup_err_d = 1'b0;
`endif
            if (WARMUP > 0) begin
                warm_cnt_d = WARM_INIT;
                fsm_d      = prng_pkg::WARMUP;
            end else begin
                fsm_d = prng_pkg::RUN;
            end
        end else if (lockup_det) begin
            state_d = SEED_DEFAULT;
`ifdef PRNG_LOCKUP_RECOVER_EN
            lockup_err_d = 1'b1;
`endif
        end else begin
            case (fsm_q)
                prng_pkg::WARMUP: begin
                    state_d    = state_adv;
                    warm_cnt_d = warm_cnt_q - 8'd1;
                    if (warm_cnt_q == 8'd1) begin
                        fsm_d = prng_pkg::RUN;
                    end
                end
                prng_pkg::RUN: begin
                    if (o_ready) begin
                        state_d = state_adv;
                    end
                end
                default: begin
                    // IDLE: hold.
                end
            endcase
        end
    end

    // State, sequencer and warm-up counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (!rst_n) begin
            state_q    <= SEED_DEFAULT;
            fsm_q      <= prng_pkg::IDLE;
            warm_cnt_q <= '0;
`ifdef PRNG_LOCKUP_RECOVER_EN
            lockup_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fsm_q      <= fsm_d;
            warm_cnt_q <= warm_cnt_d;
`ifdef PRNG_LOCKUP_RECOVER_EN
            lockup_err_q <= lockup_err_d;
`endif
        end
    end

endmodule : lfsr_prng_gen

// File: tb/tb_lfsr_prng_gen.sv
// Self-checking bench for lfsr_prng_gen. Three instances: default (no
// warm-up), WARMUP=2, and OUT_W=8/STEPS=8. Each has a scoreboard queue of
// expected words, pushed by the stimulus and popped on every handshake.
module tb_lfsr_prng_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Instance A: defaults.
    logic        a_seed_valid, a_seed_ready, a_o_valid, a_ready;
    logic [31:0] a_seed, a_o_data;
    // Instance W: two warm-up words.
    logic        w_seed_valid, w_seed_ready, w_o_valid, w_ready;
    logic [31:0] w_seed, w_o_data;
    // Instance N: 8-bit words, 8 shifts per word.
    logic        n_seed_valid, n_seed_ready, n_o_valid, n_ready;
    logic [31:0] n_seed;
    logic [7:0]  n_o_data;
`ifdef PRNG_LOCKUP_RECOVER_EN
    logic a_lockup_err, w_lockup_err, n_lockup_err;
`endif

    logic [31:0] a_q[$];
    logic [31:0] w_q[$];
    logic [7:0]  n_q[$];

    lfsr_prng_gen u_a (
        .clk(clk), .rst_n(rst_n), .seed_valid(a_seed_valid), .seed_ready(a_seed_ready),
        .seed(a_seed), .o_valid(a_o_valid), .o_ready(a_ready),
`ifdef PRNG_LOCKUP_RECOVER_EN
        .lockup_err(a_lockup_err),
`endif
        .o_data(a_o_data)
    );

    lfsr_prng_gen #(.WARMUP(2)) u_w (
        .clk(clk), .rst_n(rst_n), .seed_valid(w_seed_valid), .seed_ready(w_seed_ready),
        .seed(w_seed), .o_valid(w_o_valid), .o_ready(w_ready),
`ifdef PRNG_LOCKUP_RECOVER_EN
        .lockup_err(w_lockup_err),
`endif
        .o_data(w_o_data)
    );

    lfsr_prng_gen #(.OUT_W(8), .STEPS(8)) u_n (
        .clk(clk), .rst_n(rst_n), .seed_valid(n_seed_valid), .seed_ready(n_seed_ready),
        .seed(n_seed), .o_valid(n_o_valid), .o_ready(n_ready),
`ifdef PRNG_LOCKUP_RECOVER_EN
        .lockup_err(n_lockup_err),
`endif
        .o_data(n_o_data)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: n Galois shifts of the default 32-bit polynomial.
    function automatic logic [31:0] m_adv(input logic [31:0] s, input int n);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < n; i++) begin
            r = {r[30:0], 1'b0} ^ (r[31] ? 32'h0000_00AF : 32'h0);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: compare every accepted word, mid-cycle.
    always @(negedge clk) begin
        if (rst_n && a_o_valid && a_ready) begin
            if (a_q.size() == 0) chk("a_sb_nonempty", 64'(a_q.size()), 64'd1);
            else chk("a_word", 64'(a_o_data), 64'(a_q.pop_front()));
        end
        if (rst_n && w_o_valid && w_ready) begin
            if (w_q.size() == 0) chk("w_sb_nonempty", 64'(w_q.size()), 64'd1);
            else chk("w_word", 64'(w_o_data), 64'(w_q.pop_front()));
        end
        if (rst_n && n_o_valid && n_ready) begin
            if (n_q.size() == 0) chk("n_sb_nonempty", 64'(n_q.size()), 64'd1);
            else chk("n_word", 64'(n_o_data), 64'(n_q.pop_front()));
        end
    end

    initial begin
        logic [31:0] tmp;

        rst_n = 1'b0;
        a_seed_valid = 0; a_seed = 0; a_ready = 0;
        w_seed_valid = 0; w_seed = 0; w_ready = 0;
        n_seed_valid = 0; n_seed = 0; n_ready = 0;
        repeat (2) tick();

        // Reset values.
        chk("rst_a_valid", 64'(a_o_valid), 64'd0);
        chk("rst_a_data", 64'(a_o_data), 64'd1);
        chk("rst_a_seed_ready", 64'(a_seed_ready), 64'd0);
        chk("rst_n_data", 64'(n_o_data), 64'd1);
        chk("rst_w_valid", 64'(w_o_valid), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_seed_ready", 64'(a_seed_ready), 64'd1);
        tick();
        chk("idle_valid", 64'(a_o_valid), 64'd0);
        chk("idle_data", 64'(a_o_data), 64'd1);

        // Basic sequence and stall.
        a_seed = 32'h8000_0000; a_seed_valid = 1; a_ready = 1;
        a_q.push_back(32'h8000_0000);
        a_q.push_back(32'h0000_00AF);
        a_q.push_back(32'h0000_015E);
        a_q.push_back(m_adv(32'h0000_015E, 1));
        tick();
        a_seed_valid = 0;
        tick();
        a_ready = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(a_o_valid), 64'd1);
            chk("stall_data", 64'(a_o_data), 64'h0000_00AF);
            tick();
        end
        a_ready = 1;
        repeat (3) tick();
        a_ready = 0;
        chk("a_sb_drained_1", 64'(a_q.size()), 64'd0);

        // Zero seed is replaced by the default seed.
        a_seed = 32'h0; a_seed_valid = 1;
        a_q.push_back(32'h1); a_q.push_back(32'h2);
        a_q.push_back(32'h4); a_q.push_back(32'h8);
        tick();
        a_seed_valid = 0; a_ready = 1;
        repeat (4) tick();
        a_ready = 0;
        chk("a_sb_drained_2", 64'(a_q.size()), 64'd0);
        chk("zero_seed_hold", 64'(a_o_data), 64'h10);

        // Seed and transfer in the same RUN cycle.
        a_ready = 1; a_seed_valid = 1; a_seed = 32'h1234_5678;
        a_q.push_back(32'h10);
        a_q.push_back(32'h1234_5678);
        a_q.push_back(m_adv(32'h1234_5678, 1));
        tick();
        a_seed_valid = 0;
        repeat (2) tick();
        a_ready = 0;
        chk("a_sb_drained_3", 64'(a_q.size()), 64'd0);

        // Narrow output, eight shifts per word.
        n_seed = 32'h1; n_seed_valid = 1;
        n_q.push_back(8'h01); n_q.push_back(8'h00); n_q.push_back(8'h00);
        tmp = m_adv(32'h0001_0000, 8);
        n_q.push_back(tmp[7:0]);
        tick();
        n_seed_valid = 0; n_ready = 1;
        repeat (4) tick();
        n_ready = 0;
        chk("n_sb_drained", 64'(n_q.size()), 64'd0);
        tmp = m_adv(32'h0100_0000, 8);
        chk("n_feedback_data", 64'(n_o_data), 64'(tmp[7:0]));

        // Warm-up latency.
        w_seed = 32'h8000_0000; w_seed_valid = 1; w_ready = 1;
        w_q.push_back(32'h0000_015E);
        chk("w_seed_cycle_valid", 64'(w_o_valid), 64'd0);
        tick();
        w_seed_valid = 0;
        chk("w_warm1_valid", 64'(w_o_valid), 64'd0);
        tick();
        chk("w_warm2_valid", 64'(w_o_valid), 64'd0);
        tick();
        chk("w_first_valid", 64'(w_o_valid), 64'd1);
        tick();
        w_ready = 0;
        chk("w_sb_drained_1", 64'(w_q.size()), 64'd0);

        // Reseed mid warm-up restarts the count.
        w_seed_valid = 1;
        tick();
        w_seed_valid = 0; w_ready = 1;
        chk("w_re_warm1_valid", 64'(w_o_valid), 64'd0);
        tick();
        w_seed_valid = 1;
        w_q.push_back(32'h0000_015E);
        chk("w_re_warm2_valid", 64'(w_o_valid), 64'd0);
        tick();
        w_seed_valid = 0;
        chk("w_restart1_valid", 64'(w_o_valid), 64'd0);
        tick();
        chk("w_restart2_valid", 64'(w_o_valid), 64'd0);
        tick();
        chk("w_restart_first_valid", 64'(w_o_valid), 64'd1);
        tick();
        w_ready = 0;
        chk("w_sb_drained_2", 64'(w_q.size()), 64'd0);

`ifdef PRNG_LOCKUP_RECOVER_EN
        // Forced all-zero state in RUN recovers to the default seed.
        a_seed = 32'h1234; a_seed_valid = 1;
        tick();
        a_seed_valid = 0;
        chk("lk_err_clear", 64'(a_lockup_err), 64'd0);
        force u_a.state_q = '0;
        #1;
        release u_a.state_q;
        chk("lk_detect_valid", 64'(a_o_valid), 64'd0);
        tick();
        chk("lk_recovered_valid", 64'(a_o_valid), 64'd1);
        chk("lk_recovered_data", 64'(a_o_data), 64'd1);
        chk("lk_err_set", 64'(a_lockup_err), 64'd1);
        tick();
        chk("lk_err_sticky", 64'(a_lockup_err), 64'd1);
        a_seed = 32'h5; a_seed_valid = 1;
        tick();
        a_seed_valid = 0;
        chk("lk_err_cleared", 64'(a_lockup_err), 64'd0);
`endif

        // Reset in the middle of warm-up.
        w_seed_valid = 1;
        tick();
        w_seed_valid = 0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("w_rst_valid", 64'(w_o_valid), 64'd0);
        chk("w_rst_data", 64'(w_o_data), 64'd1);
        chk("w_rst_seed_ready", 64'(w_seed_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("w_post_rst_idle", 64'(w_o_valid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_lfsr_prng_gen
